// File: rtl/axi_ads124x_pkg.sv
// Shared types and constants for the ADS124x SPI command arbiter.
package axi_ads124x_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TX    = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 4096;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/axi_ads124x_spi_arb.sv
// Two-requester round-robin arbiter that serialises command words into an SPI
// byte stream and assembles the returned bytes into a per-requester response.
module axi_ads124x_spi_arb
    import axi_ads124x_pkg::*;
#(
    parameter int unsigned C_TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] req0_txdata,
    input  logic [1:0]  req0_nbytes,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req1_txdata,
    input  logic [1:0]  req1_nbytes,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp0_valid,
    output logic        rsp0_err,
    output logic [31:0] rsp1_data,
    output logic        rsp1_valid,
    output logic        rsp1_err,
    output logic [7:0]  spitx_axis_tdata,
    output logic        spitx_axis_tvalid,
    input  logic        spitx_axis_tready,
    input  logic [7:0]  spirx_axis_tdata,
    input  logic        spirx_axis_tvalid,
    output logic        spirx_axis_tready,
    output logic        busy,
    output logic        grant_id
);

    localparam int unsigned TMO_W = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT - 1);

    arb_state_t         state, state_next;
    logic               grant_q;
    logic               pick, any_valid;
    logic [31:0]        sel_txdata;
    logic [1:0]         sel_nbytes;
    logic [31:0]        txdata_q;
    logic [1:0]         nbytes_q;
    logic [2:0]         tx_cnt, rx_cnt, rx_cnt_next, xfer_len;
    logic [31:0]        rx_buf, rx_buf_next;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tx_valid_q;
    logic [7:0]         tx_data_q;
    logic [1:0]         rsp_valid_q, rsp_err_q;
    logic [1:0][31:0]   rsp_data_q;
    logic               active, tx_fire, rx_take, progress, last_tx, rx_complete, tmo_hit;
    logic [1:0]         next_idx;

    // Ties go to the requester that did not own the bus last.
    assign any_valid  = req0_valid | req1_valid;
    assign pick       = (req0_valid && req1_valid) ? ~grant_q : req1_valid;
    assign sel_txdata = pick ? req1_txdata : req0_txdata;
    assign sel_nbytes = pick ? req1_nbytes : req0_nbytes;
    assign req0_ready = (state == S_IDLE) && req0_valid && !pick;
    assign req1_ready = (state == S_IDLE) && req1_valid && pick;

    assign active      = (state == S_TX) || (state == S_DRAIN);
    assign xfer_len    = {1'b0, nbytes_q} + 3'd1;
    assign tx_fire     = tx_valid_q && spitx_axis_tready;
    assign rx_take     = active && spirx_axis_tvalid && (rx_cnt < xfer_len);
    assign progress    = tx_fire || (active && spirx_axis_tvalid);
    assign last_tx     = tx_fire && (tx_cnt == {1'b0, nbytes_q});
    assign rx_cnt_next = rx_cnt + {2'b00, rx_take};
    assign rx_buf_next = rx_take ? {rx_buf[23:0], spirx_axis_tdata} : rx_buf;
    assign rx_complete = (rx_cnt_next == xfer_len);
    assign tmo_hit     = active && !progress && (tmo_cnt == TMO_LAST);
    assign next_idx    = nbytes_q - tx_cnt[1:0] - 2'd1;

    always_comb begin
        // NOTE: next state defaults to the current one so no path leaves it unassigned (no latch).
        state_next = state;
        unique case (state)
            S_IDLE:  if (any_valid) state_next = S_TX;
            S_TX: begin
                if (tmo_hit)      state_next = S_RESP;
                else if (last_tx) state_next = rx_complete ? S_RESP : S_DRAIN;
            end
            S_DRAIN: if (tmo_hit || rx_complete) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q     <= 1'b1;
            txdata_q    <= '0;
            nbytes_q    <= '0;
            tx_cnt      <= '0;
            rx_cnt      <= '0;
            rx_buf      <= '0;
            tmo_cnt     <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            rsp_valid_q <= '0;
            unique case (state)
                S_IDLE: if (any_valid) begin
                    grant_q    <= pick;
                    txdata_q   <= sel_txdata;
                    nbytes_q   <= sel_nbytes;
                    tx_cnt     <= '0;
                    rx_cnt     <= '0;
                    rx_buf     <= '0;
                    tmo_cnt    <= '0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= pick_byte(sel_txdata, sel_nbytes);
                end
                S_TX, S_DRAIN: begin
                    tmo_cnt <= progress ? '0 : tmo_cnt + 1'b1;
                    if (rx_take) begin
                        rx_buf <= rx_buf_next;
                        rx_cnt <= rx_cnt_next;
                    end
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt + 3'd1;
                        if (last_tx) tx_valid_q <= 1'b0;
                        else         tx_data_q  <= pick_byte(txdata_q, next_idx);
                    end
                    // Response registers load on the way into S_RESP so they line up with it.
                    if (state_next == S_RESP) begin
                        tx_valid_q           <= 1'b0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_data_q[grant_q]  <= rx_buf_next;
                        rsp_err_q[grant_q]   <= tmo_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spitx_axis_tdata  = tx_data_q;
    assign spitx_axis_tvalid = tx_valid_q;
    assign spirx_axis_tready = 1'b1;
    assign rsp0_valid        = rsp_valid_q[0];
    assign rsp1_valid        = rsp_valid_q[1];
    assign rsp0_data         = rsp_data_q[0];
    assign rsp1_data         = rsp_data_q[1];
    assign rsp0_err          = rsp_err_q[0];
    assign rsp1_err          = rsp_err_q[1];
    assign busy              = (state != S_IDLE);
    assign grant_id          = grant_q;

endmodule

// File: tb/tb_axi_ads124x_spi_arb.sv
// Scoreboard bench: requests push expected tx bytes and responses; a negedge
// monitor emulates the SPI engine and compares everything the DUT presents.
module tb_axi_ads124x_spi_arb;

    localparam int unsigned TMO = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] req0_txdata, req1_txdata;
    logic [1:0]  req0_nbytes, req1_nbytes;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [7:0]  spitx_axis_tdata, spirx_axis_tdata;
    logic        spitx_axis_tvalid, spitx_axis_tready;
    logic        spirx_axis_tvalid, spirx_axis_tready;
    logic        busy, grant_id;

    always #5 aclk = ~aclk;

    axi_ads124x_spi_arb #(.C_TIMEOUT(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req0_txdata(req0_txdata), .req0_nbytes(req0_nbytes), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_txdata(req1_txdata), .req1_nbytes(req1_nbytes), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
        .rsp1_data(rsp1_data), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
        .spitx_axis_tdata(spitx_axis_tdata), .spitx_axis_tvalid(spitx_axis_tvalid), .spitx_axis_tready(spitx_axis_tready),
        .spirx_axis_tdata(spirx_axis_tdata), .spirx_axis_tvalid(spirx_axis_tvalid), .spirx_axis_tready(spirx_axis_tready),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        rsp_exp[$];
    logic [7:0]  tx_exp[$], rx_src[$], rx_pending[$], rx_plan[$];
    int          vectors = 0, miscompares = 0;
    int          cyc = 0, last_prog_edge = 0, stall_until = 0;
    int          junk_req = 0, junk_done = 0;
    bit          rx_silent = 1'b0;
    bit          rand_mode = 1'b0;
    logic        model_last = 1'b1;
    logic [31:0] hold_data[2];
    logic        hold_err[2];
    logic        prev_stall;
    logic [7:0]  prev_tdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not as expected (cycle %0d)", name, cyc);
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        if (cyc < stall_until) spitx_axis_tready = 1'b0;
        else if (rand_mode)    spitx_axis_tready = ($urandom_range(0, 3) != 0);
        else                   spitx_axis_tready = 1'b1;
    end

    // Monitor and SPI-engine model: sample, compare, then drive the rx beat for the next edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            tx_exp.delete(); rx_src.delete(); rx_pending.delete(); rsp_exp.delete();
            hold_data[0] = '0; hold_data[1] = '0; hold_err[0] = 1'b0; hold_err[1] = 1'b0;
            prev_stall = 1'b0;
            spirx_axis_tvalid = 1'b0;
            spirx_axis_tdata  = '0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", 64'(spitx_axis_tvalid), 64'd1);
                check("tx_hold_data", 64'(spitx_axis_tdata), 64'(prev_tdata));
            end
            prev_stall = spitx_axis_tvalid && !spitx_axis_tready;
            prev_tdata = spitx_axis_tdata;

            if (spitx_axis_tvalid && spitx_axis_tready) begin
                last_prog_edge = cyc + 1;
                if (tx_exp.size() == 0) fail_now("tx_unexpected_byte");
                else check("tx_byte", 64'(spitx_axis_tdata), 64'(tx_exp.pop_front()));
                if (rx_src.size() > 0) rx_pending.push_back(rx_src.pop_front());
            end

            if (rsp0_valid || rsp1_valid) begin
                rsp_t e;
                check("rsp_onehot", 64'(rsp0_valid & rsp1_valid), 64'd0);
                if (rsp_exp.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    e = rsp_exp.pop_front();
                    check("rsp_id", 64'(rsp1_valid), 64'(e.id));
                    hold_data[e.id] = e.data;
                    hold_err[e.id]  = e.err;
                    if (e.err) begin
                        check("tmo_idle_cycles", 64'(cyc - last_prog_edge), 64'(TMO));
                        check("tmo_tvalid_low", 64'(spitx_axis_tvalid), 64'd0);
                    end
                end
            end
            check("rsp0_hold", {31'd0, rsp0_err, rsp0_data}, {31'd0, hold_err[0], hold_data[0]});
            check("rsp1_hold", {31'd0, rsp1_err, rsp1_data}, {31'd0, hold_err[1], hold_data[1]});

            if (rx_pending.size() > 0 && !(rand_mode && $urandom_range(0, 2) == 0)) begin
                spirx_axis_tvalid = 1'b1;
                spirx_axis_tdata  = rx_pending.pop_front();
            end else if (junk_done != junk_req) begin
                spirx_axis_tvalid = 1'b1;
                spirx_axis_tdata  = 8'h5A;
                junk_done++;
            end else begin
                spirx_axis_tvalid = 1'b0;
            end
        end
    end

    // Reference model for one accepted command: bytes go out high index first,
    // returned bytes pack into the response with the first byte most significant.
    task automatic accept_model(input logic id, input logic [31:0] d, input logic [1:0] nb);
        rsp_t       e;
        logic [7:0] b;
        int         n;
        n      = int'(nb);
        e.id   = id;
        e.data = '0;
        e.err  = rx_silent;
        for (int i = n; i >= 0; i--) tx_exp.push_back(d[8*i +: 8]);
        if (!rx_silent) begin
            for (int i = 0; i <= n; i++) begin
                b = (rx_plan.size() > 0) ? rx_plan.pop_front() : 8'($urandom_range(0, 255));
                rx_src.push_back(b);
                e.data = (e.data << 8) | {24'd0, b};
            end
        end
        rsp_exp.push_back(e);
    endtask

    task automatic serve(input bit p0, input bit p1, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] n0, input logic [1:0] n1);
        bit   pend0, pend1;
        int   budget;
        logic exp_w;
        pend0  = p0;
        pend1  = p1;
        budget = 0;
        while ((pend0 || pend1) && budget < 400) begin
            @(posedge aclk); #1;
            req0_valid = pend0; req0_txdata = d0; req0_nbytes = n0;
            req1_valid = pend1; req1_txdata = d1; req1_nbytes = n1;
            @(negedge aclk);
            budget++;
            if (busy) check("ready_low_while_busy", {62'd0, req1_ready, req0_ready}, 64'd0);
            if (req0_ready || req1_ready) begin
                exp_w = (pend0 && pend1) ? ~model_last : pend1;
                check("grant_sel", {62'd0, req1_ready, req0_ready}, exp_w ? 64'd2 : 64'd1);
                model_last = exp_w;
                accept_model(exp_w, exp_w ? d1 : d0, exp_w ? n1 : n0);
                if (exp_w) pend1 = 1'b0;
                else       pend0 = 1'b0;
            end
        end
        if (pend0 || pend1) fail_now("serve_timeout");
        @(posedge aclk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("grant_id", 64'(grant_id), 64'(model_last));
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((rsp_exp.size() != 0 || busy) && budget < 500) begin
            @(negedge aclk);
            budget++;
        end
        if (budget >= 500) fail_now("idle_timeout");
        @(negedge aclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, 64'(spitx_axis_tvalid), 64'd0);
        check({tag, "_tdata"}, 64'(spitx_axis_tdata), 64'd0);
        check({tag, "_rsp_valid"}, {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
        check({tag, "_rsp0"}, {31'd0, rsp0_err, rsp0_data}, 64'd0);
        check({tag, "_rsp1"}, {31'd0, rsp1_err, rsp1_data}, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant_id"}, 64'(grant_id), 64'd1);
        check({tag, "_rx_tready"}, 64'(spirx_axis_tready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0, r1;
        aresetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_txdata = '0; req1_txdata = '0; req0_nbytes = '0; req1_nbytes = '0;
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        @(posedge aclk); #3;
        aresetn = 1'b1;

        // Tie right after reset: requester 0 first, then 1; later ties alternate.
        serve(1'b1, 1'b1, $urandom, $urandom, 2'd1, 2'd3);
        wait_idle();
        serve(1'b1, 1'b0, $urandom, '0, 2'd0, 2'd0);
        wait_idle();
        serve(1'b1, 1'b1, $urandom, $urandom, 2'd2, 2'd0);
        wait_idle();

        rx_plan.push_back(8'hAA); rx_plan.push_back(8'hBB); rx_plan.push_back(8'hCC);
        serve(1'b1, 1'b0, 32'h0040_0017, '0, 2'd2, 2'd0);
        wait_idle();
        check("adc_read_data", {31'd0, rsp0_err, rsp0_data}, 64'h0000_0000_00AA_BBCC);

        serve(1'b1, 1'b0, 32'h0000_00FF, '0, 2'd0, 2'd0);
        wait_idle();

        // Ten-cycle tready stall while the second byte is presented.
        serve(1'b0, 1'b1, '0, $urandom, 2'd0, 2'd3);
        @(negedge aclk);
        @(negedge aclk);
        stall_until = cyc + 11;
        wait_idle();

        rx_silent = 1'b1;
        serve(1'b0, 1'b1, '0, $urandom, 2'd0, 2'd2);
        wait_idle();
        rx_silent = 1'b0;

        junk_req++;
        repeat (3) @(negedge aclk);
        serve(1'b1, 1'b0, $urandom, '0, 2'd1, 2'd0);
        wait_idle();

        // Reset in the middle of a transfer: no response, then normal operation.
        serve(1'b1, 1'b0, $urandom, '0, 2'd3, 2'd0);
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_last = 1'b1;
        repeat (2) @(negedge aclk);
        @(posedge aclk); #3;
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        serve(1'b1, 1'b1, $urandom, $urandom, 2'd2, 2'd1);
        wait_idle();

        rand_mode = 1'b1;
        repeat (40) begin
            bit p0, p1;
            p0 = 1'($urandom_range(0, 1));
            p1 = p0 ? 1'($urandom_range(0, 1)) : 1'b1;
            r0 = $urandom;
            r1 = $urandom;
            serve(p0, p1, r0, r1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        rand_mode = 1'b0;

        check("tx_queue_drained", 64'(tx_exp.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_exp.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
